// File: rtl/fifo_pkg.sv
// fifo_pkg: shared width helper and flag-threshold defaults for param_fifo.
package fifo_pkg;
  localparam int AE_TH_DEF = 2;
  localparam int AF_GAP = 2;
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DATA_W x DEPTH storage, one synchronous write port, one asynchronous read port, no reset.
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/param_fifo.sv
// param_fifo: synchronous FIFO with status flags and sticky error flags.
// Define PARAM_FIFO_FWFT_EN for first-word-fall-through reads; default is registered 1-cycle read.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16,
  parameter int AF_TH = DEPTH - AF_GAP,
  parameter int AE_TH = AE_TH_DEF,
  localparam int PW = ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              en_write,
  input  logic              en_read,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [PW-1:0]     count,
  output logic              overflow,
  output logic              underflow
);
  localparam int AW = PW - 1;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem_q;
  logic rd_ok, wr_ok;
  assign empty = wr_ptr == rd_ptr;
  assign full = wr_ptr[AW-1:0] == rd_ptr[AW-1:0] && wr_ptr[AW] != rd_ptr[AW];
  assign count = wr_ptr - rd_ptr;
  assign almost_full = int'(count) >= AF_TH;
  assign almost_empty = int'(count) <= AE_TH;
  assign rd_ok = en_read && !empty;
  // a full FIFO still takes a write when the head leaves in the same cycle
  assign wr_ok = en_write && (!full || rd_ok);
  fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .we(wr_ok),
    .waddr(wr_ptr[AW-1:0]),
    .wdata(data_in),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(mem_q)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PW'(1);
      overflow <= overflow | (en_write & ~wr_ok);
      underflow <= underflow | (en_read & empty);
    end
`ifdef PARAM_FIFO_FWFT_EN
  assign data_out = mem_q;
  assign rd_valid = !empty;
`else
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      data_out <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      if (rd_ok) data_out <= mem_q;
    end
`endif
endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo: scoreboard bench for param_fifo against a queue-based reference model.
module tb_param_fifo;
  logic clk = 0, reset = 0, en_write = 0, en_read = 0;
  logic [7:0] data_in = 0, data_out;
  logic rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;
  int n_chk = 0, n_fail = 0;
  int mq[$];
  int eq[$];
  bit m_ovf = 0, m_unf = 0;

  param_fifo dut (
    .clk(clk), .reset(reset), .data_in(data_in), .en_write(en_write), .en_read(en_read),
    .data_out(data_out), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic pop_chk();
    if (eq.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL data: unexpected word %0h with nothing expected at %0t", data_out, $time);
    end else chk("data", data_out, eq.pop_front());
  endtask

  // status flags against the model after every edge
  always @(posedge clk) begin
    #1;
    chk("count", count, mq.size());
    chk("full", full, mq.size() == 16);
    chk("empty", empty, mq.size() == 0);
    chk("almost_full", almost_full, mq.size() >= 14);
    chk("almost_empty", almost_empty, mq.size() <= 2);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_unf);
`ifndef PARAM_FIFO_FWFT_EN
    if (rd_valid) pop_chk();
`endif
  end

`ifdef PARAM_FIFO_FWFT_EN
  always @(negedge clk) begin
    #2;
    if (en_read && rd_valid) pop_chk();
  end
`endif

  task automatic step(input bit w, input bit r, input int d);
    bit rd_acc, wr_acc;
    @(negedge clk);
    en_write = w;
    en_read = r;
    data_in = 8'(d);
    rd_acc = r && mq.size() > 0;
    wr_acc = w && (mq.size() < 16 || rd_acc);
    if (r && mq.size() == 0) m_unf = 1;
    if (w && !wr_acc) m_ovf = 1;
    if (rd_acc) eq.push_back(mq.pop_front());
    if (wr_acc) mq.push_back(d & 8'hFF);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic do_reset();
    idle(2);
    @(posedge clk);
    #3;
    chk("pending", eq.size(), 0);
    reset = 0;
    mq.delete();
    eq.delete();
    m_ovf = 0;
    m_unf = 0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    chk("rst_valid", rd_valid, 0);
    @(negedge clk);
    reset = 1;
  endtask

  initial begin
    #2;
    chk("init_count", count, 0);
    chk("init_empty", empty, 1);
    @(negedge clk);
    reset = 1;
    for (int i = 1; i <= 16; i++) step(1, 0, i);
    step(1, 0, 8'h77);
    idle(1);
    @(posedge clk);
    #1;
    chk("fill_count", count, 16);
    chk("fill_ovf", overflow, 1);
    for (int i = 0; i < 16; i++) step(0, 1, 0);
    idle(1);
    step(0, 1, 0);
    idle(1);
    @(posedge clk);
    #1;
    chk("drain_unf", underflow, 1);
    chk("drain_empty", empty, 1);
`ifndef PARAM_FIFO_FWFT_EN
    chk("drain_held", data_out, 8'h10);
`endif
    do_reset();
    step(1, 1, 8'h55);
    idle(1);
    @(posedge clk);
    #1;
    chk("es_unf", underflow, 1);
    chk("es_count", count, 1);
    step(0, 1, 0);
    idle(2);
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 0, $urandom_range(0, 255));
    step(1, 1, 8'hAA);
    idle(1);
    @(posedge clk);
    #1;
    chk("sim_count", count, 16);
    chk("sim_ovf", overflow, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 0);
    idle(2);
    begin
      int writes = 0;
      while (writes < 40) begin
        bit w, r;
        w = mq.size() < 3 ? 1'b1 : mq.size() >= 7 ? 1'b0 : 1'($urandom_range(0, 1));
        r = mq.size() <= 3 ? 1'b0 : mq.size() >= 7 ? 1'b1 : 1'($urandom_range(0, 1));
        if (w) writes++;
        step(w, r, $urandom_range(0, 255));
      end
    end
    while (mq.size() > 5) step(0, 1, 0);
    while (mq.size() < 5) step(1, 0, $urandom_range(0, 255));
    do_reset();
    step(1, 0, 8'h3C);
    step(0, 1, 0);
    idle(2);
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 255));
    while (mq.size() > 0) step(0, 1, 0);
    idle(3);
    chk("sb_drained", eq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
